// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: request formats, opcodes, error codes and
// immediate range limits used by the decoder and the program loader.
package legv8_pkg;

  typedef enum logic [1:0] {
    FMT_LDUR = 2'b00,
    FMT_STUR = 2'b01,
    FMT_CBZ  = 2'b10,
    FMT_RSVD = 2'b11
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10,
    ST_FULL = 2'b11
  } enc_state_e;

  localparam logic [10:0] OPC_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OPC_STUR = 11'b111_1100_0000;
  localparam logic [7:0]  OPC_CBZ  = 8'b1011_0100;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_FMT   = 2'b11;

  // D-format carries a 9-bit signed byte offset.
  localparam logic signed [63:0] D_IMM_MIN   = -64'sd256;
  localparam logic signed [63:0] D_IMM_MAX   = 64'sd255;
  // CBZ carries a 19-bit signed word offset, so byte offsets are multiples of 4.
  localparam logic signed [63:0] CBZ_IMM_MIN = -64'sd1048576;
  localparam logic signed [63:0] CBZ_IMM_MAX = 64'sd1048572;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: turns one symbolic request into a LEGv8 word and
// reports whether the immediate survives a round trip through signext.
module instr_pack
  import legv8_pkg::*;
(
  input  logic [1:0]         fmt,
  input  logic [4:0]         rt,
  input  logic [4:0]         rn,
  input  logic signed [63:0] imm,
  output logic [31:0]        word,
  output logic               ok,
  output logic [1:0]         code
);

  // Encode and range-check; fmt is checked first, then alignment, then range.
  always_comb begin
    word = '0;
    ok   = 1'b0;
    code = ERR_NONE;
    case (fmt)
      FMT_LDUR, FMT_STUR: begin
        word = {(fmt == FMT_LDUR) ? OPC_LDUR : OPC_STUR, imm[8:0], 2'b00, rn, rt};
        if (imm >= D_IMM_MIN && imm <= D_IMM_MAX) ok = 1'b1;
        else                                      code = ERR_RANGE;
      end
      FMT_CBZ: begin
        word = {OPC_CBZ, imm[20:2], rt};
        if (imm[1:0] != 2'b00)                              code = ERR_ALIGN;
        else if (imm >= CBZ_IMM_MIN && imm <= CBZ_IMM_MAX) ok = 1'b1;
        else                                                code = ERR_RANGE;
      end
      default: code = ERR_FMT;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts symbolic LDUR/STUR/CBZ requests, packs them and
// writes the words into instruction memory at an auto-incrementing address.
module instr_encoder
  import legv8_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_fmt,
  input  logic [4:0]          in_rt,
  input  logic [4:0]          in_rn,
  input  logic signed [63:0]  in_imm,
  input  logic                in_last,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [31:0]         imem_wdata,
  output logic                err,
  output logic [1:0]          err_code,
  output logic [7:0]          err_count,
  output logic [ADDR_W:0]     words,
  output logic                done,
  output logic                full
);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  enc_state_e        state_q, state_d;
  logic              stall;
  logic              accept;
  logic              term;
  logic              last_slot;
  logic [ADDR_W-1:0] pend_addr;

  logic [31:0]       pk_word;
  logic              pk_ok;
  logic [1:0]        pk_code;

  logic              vld_p1;
  logic              err_p1;
  logic [31:0]       wdata_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [ADDR_W:0]   words_p1;
  logic [1:0]        code_p1;
  logic [7:0]        ecnt_p1;

  instr_pack u_pack (
    .fmt  (in_fmt),
    .rt   (in_rt),
    .rn   (in_rn),
    .imm  (in_imm),
    .word (pk_word),
    .ok   (pk_ok),
    .code (pk_code)
  );

  // The address a newly accepted beat will write, accounting for the
  // increment still pending from the write currently on the strobe.
  always_comb begin
    pend_addr = addr_p1 + (vld_p1 ? ADDR_W'(1) : '0);
    last_slot = (pend_addr == {ADDR_W{1'b1}});
    accept    = in_valid && in_ready;
    term      = accept && (in_last || (pk_ok && last_slot));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: start wins everywhere; last outranks the final address.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_RUN;
    end else if (state_q == ST_RUN && accept) begin
      if (in_last)                state_d = ST_DONE;
      else if (pk_ok && last_slot) state_d = ST_FULL;
    end
  end

  // Stall flag blocks intake for the cycle after a terminal beat.
  always_ff @(posedge clk) begin
    if (reset || start) stall <= 1'b0;
    else                stall <= term;
  end

  // Stage p1: registered write/error strobe plus address and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
      wdata_p1 <= '0;
      addr_p1  <= '0;
      words_p1 <= '0;
      code_p1  <= ERR_NONE;
      ecnt_p1  <= '0;
    end else if (start) begin
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
      addr_p1  <= '0;
      words_p1 <= '0;
      code_p1  <= ERR_NONE;
      ecnt_p1  <= '0;
    end else begin
      vld_p1 <= accept && pk_ok;
      err_p1 <= accept && !pk_ok;
      if (accept && pk_ok) wdata_p1 <= pk_word;
      if (vld_p1) begin
        words_p1 <= words_p1 + (ADDR_W+1)'(1);
        if (addr_p1 != {ADDR_W{1'b1}}) addr_p1 <= addr_p1 + ADDR_W'(1);
      end
      if (accept && !pk_ok) begin
        code_p1 <= pk_code;
        ecnt_p1 <= sat_inc8(ecnt_p1);
      end
    end
  end

  assign in_ready   = (state_q == ST_RUN) && !stall;
  assign imem_we    = vld_p1;
  assign imem_addr  = addr_p1;
  assign imem_wdata = wdata_p1;
  assign err        = err_p1;
  assign err_code   = code_p1;
  assign err_count  = ecnt_p1;
  assign words      = words_p1;
  assign done       = (state_q == ST_DONE);
  assign full       = (state_q == ST_FULL);

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: single-beat vector table plus
// hand-written multi-beat sequences.
module tb_instr_encoder;

  localparam int AW = 2;

  logic               clk = 1'b0;
  logic               reset, start, in_valid, in_last;
  logic               in_ready;
  logic [1:0]         in_fmt;
  logic [4:0]         in_rt, in_rn;
  logic signed [63:0] in_imm;
  logic               imem_we, err, done, full;
  logic [AW-1:0]      imem_addr;
  logic [31:0]        imem_wdata;
  logic [1:0]         err_code;
  logic [7:0]         err_count;
  logic [AW:0]        words;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fmt     (in_fmt),
    .in_rt      (in_rt),
    .in_rn      (in_rn),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .err        (err),
    .err_code   (err_code),
    .err_count  (err_count),
    .words      (words),
    .done       (done),
    .full       (full)
  );

  typedef struct {
    logic [1:0]         fmt;
    logic [4:0]         rt;
    logic [4:0]         rn;
    logic signed [63:0] imm;
    logic               ok;
    logic [31:0]        wdata;
    logic [1:0]         code;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] f, input logic [4:0] rt,
                       input logic [4:0] rn, input logic signed [63:0] imm, input logic last);
    in_valid = v; in_fmt = f; in_rt = rt; in_rn = rn; in_imm = imm; in_last = last;
  endtask

  initial begin
    int nw;
    vecs[0]  = '{2'b00, 5'd1,  5'd2, -64'sd256,      1'b1, 32'hF8500041, 2'b00};
    vecs[1]  = '{2'b01, 5'd3,  5'd4, 64'sd1,         1'b1, 32'hF8001083, 2'b00};
    vecs[2]  = '{2'b10, 5'd5,  5'd9, -64'sd1024,     1'b1, 32'hB4FFE005, 2'b00};
    vecs[3]  = '{2'b00, 5'd0,  5'd0, 64'sd256,       1'b0, 32'h0,        2'b01};
    vecs[4]  = '{2'b01, 5'd0,  5'd0, -64'sd257,      1'b0, 32'h0,        2'b01};
    vecs[5]  = '{2'b00, 5'd0,  5'd0, 64'sd255,       1'b1, 32'hF84FF000, 2'b00};
    vecs[6]  = '{2'b10, 5'd0,  5'd0, 64'sd6,         1'b0, 32'h0,        2'b10};
    vecs[7]  = '{2'b10, 5'd0,  5'd0, 64'sd1048576,   1'b0, 32'h0,        2'b01};
    vecs[8]  = '{2'b10, 5'd0,  5'd0, 64'sd1048572,   1'b1, 32'hB47FFFE0, 2'b00};
    vecs[9]  = '{2'b10, 5'd31, 5'd0, -64'sd1048576,  1'b1, 32'hB480001F, 2'b00};
    vecs[10] = '{2'b11, 5'd0,  5'd0, 64'sd0,         1'b0, 32'h0,        2'b11};
    vecs[11] = '{2'b10, 5'd0,  5'd0, -64'sd1048580,  1'b0, 32'h0,        2'b01};
    vecs[12] = '{2'b00, 5'd0,  5'd0, 64'sh8000_0000_0000_0000, 1'b0, 32'h0, 2'b01};
    vecs[13] = '{2'b10, 5'd0,  5'd0, 64'sd2097154,   1'b0, 32'h0,        2'b10};
    vecs[14] = '{2'b11, 5'd0,  5'd0, 64'sd5000,      1'b0, 32'h0,        2'b11};

    reset = 1'b1; start = 1'b0;
    drive(1'b0, 2'b00, 5'd0, 5'd0, 64'sd0, 1'b0);
    step(); step();
    chk("rst_ready", in_ready, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_err", err, 0);
    chk("rst_done", done, 0);
    chk("rst_full", full, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_words", words, 0);
    chk("rst_ecnt", err_count, 0);
    chk("rst_ecode", err_code, 0);
    reset = 1'b0;
    step();
    chk("idle_ready", in_ready, 0);

    // Single-beat programs, each marked last.
    for (int i = 0; i < 15; i++) begin
      start = 1'b1; step(); start = 1'b0;
      chk($sformatf("v%0d_ready", i), in_ready, 1);
      drive(1'b1, vecs[i].fmt, vecs[i].rt, vecs[i].rn, vecs[i].imm, 1'b1);
      step();
      drive(1'b0, 2'b00, 5'd0, 5'd0, 64'sd0, 1'b0);
      chk($sformatf("v%0d_we", i), imem_we, vecs[i].ok);
      chk($sformatf("v%0d_err", i), err, !vecs[i].ok);
      chk($sformatf("v%0d_addr", i), imem_addr, 0);
      if (vecs[i].ok) chk($sformatf("v%0d_wdata", i), imem_wdata, vecs[i].wdata);
      chk($sformatf("v%0d_code", i), err_code, vecs[i].code);
      chk($sformatf("v%0d_done", i), done, 1);
      chk($sformatf("v%0d_ecnt", i), err_count, vecs[i].ok ? 0 : 1);
      step();
      chk($sformatf("v%0d_words", i), words, vecs[i].ok ? 1 : 0);
      chk($sformatf("v%0d_we2", i), imem_we, 0);
      chk($sformatf("v%0d_err2", i), err, 0);
      chk($sformatf("v%0d_ready2", i), in_ready, 0);
      chk($sformatf("v%0d_done2", i), done, 1);
    end

    // STUR then CBZ(last), back to back.
    start = 1'b1; step(); start = 1'b0;
    drive(1'b1, 2'b01, 5'd3, 5'd4, 64'sd1, 1'b0);
    step();
    chk("seq2_we0", imem_we, 1);
    chk("seq2_addr0", imem_addr, 0);
    chk("seq2_wd0", imem_wdata, 32'hF8001083);
    chk("seq2_done0", done, 0);
    chk("seq2_ready0", in_ready, 1);
    drive(1'b1, 2'b10, 5'd5, 5'd0, -64'sd1024, 1'b1);
    step();
    drive(1'b0, 2'b00, 5'd0, 5'd0, 64'sd0, 1'b0);
    chk("seq2_we1", imem_we, 1);
    chk("seq2_addr1", imem_addr, 1);
    chk("seq2_wd1", imem_wdata, 32'hB4FFE005);
    chk("seq2_done1", done, 1);
    chk("seq2_ready1", in_ready, 0);
    step();
    chk("seq2_words", words, 2);
    chk("seq2_we2", imem_we, 0);

    // Two rejected requests: range then alignment.
    start = 1'b1; step(); start = 1'b0;
    drive(1'b1, 2'b00, 5'd1, 5'd1, 64'sd256, 1'b0);
    step();
    chk("seq3_err0", err, 1);
    chk("seq3_code0", err_code, 2'b01);
    chk("seq3_we0", imem_we, 0);
    drive(1'b1, 2'b10, 5'd1, 5'd0, 64'sd6, 1'b0);
    step();
    drive(1'b0, 2'b00, 5'd0, 5'd0, 64'sd0, 1'b0);
    chk("seq3_err1", err, 1);
    chk("seq3_code1", err_code, 2'b10);
    chk("seq3_ecnt", err_count, 2);
    step();
    chk("seq3_err2", err, 0);
    chk("seq3_addr", imem_addr, 0);
    chk("seq3_words", words, 0);
    chk("seq3_ready", in_ready, 1);

    // Fill all four addresses; the fifth request must not be taken.
    start = 1'b1; step(); start = 1'b0;
    nw = 0;
    for (int c = 0; c < 7; c++) begin
      drive(1'b1, 2'b00, 5'(nw), 5'd0, 64'sd8, 1'b0);
      step();
      if (imem_we) begin
        chk($sformatf("full_addr%0d", nw), imem_addr, nw);
        chk($sformatf("full_rt%0d", nw), imem_wdata[4:0], nw);
        nw++;
        if (nw == 4) chk("full_rise", full, 1);
      end
    end
    drive(1'b0, 2'b00, 5'd0, 5'd0, 64'sd0, 1'b0);
    chk("full_nwrites", nw, 4);
    chk("full_words", words, 4);
    chk("full_flag", full, 1);
    chk("full_done", done, 0);
    chk("full_ready", in_ready, 0);
    chk("full_addr", imem_addr, 3);

    // start while a beat is in flight.
    start = 1'b1; step(); start = 1'b0;
    drive(1'b1, 2'b00, 5'd0, 5'd0, 64'sd300, 1'b0);
    step();
    drive(1'b1, 2'b00, 5'd2, 5'd0, 64'sd4, 1'b0);
    step();
    chk("st_we_pre", imem_we, 1);
    chk("st_ecnt_pre", err_count, 1);
    start = 1'b1;
    drive(1'b1, 2'b00, 5'd3, 5'd0, 64'sd4, 1'b0);
    step();
    start = 1'b0;
    drive(1'b0, 2'b00, 5'd0, 5'd0, 64'sd0, 1'b0);
    chk("st_we", imem_we, 0);
    chk("st_err", err, 0);
    chk("st_addr", imem_addr, 0);
    chk("st_words", words, 0);
    chk("st_ecnt", err_count, 0);
    chk("st_ecode", err_code, 0);
    chk("st_ready", in_ready, 1);
    step();
    chk("st_we2", imem_we, 0);
    chk("st_words2", words, 0);

    // reset mid-RUN with a write on the strobe.
    drive(1'b1, 2'b01, 5'd1, 5'd1, 64'sd8, 1'b0);
    step();
    chk("rr_we_pre", imem_we, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, 2'b00, 5'd0, 5'd0, 64'sd0, 1'b0);
    chk("rr_we", imem_we, 0);
    chk("rr_addr", imem_addr, 0);
    chk("rr_words", words, 0);
    chk("rr_ecnt", err_count, 0);
    chk("rr_ready", in_ready, 0);
    step();
    chk("rr_we2", imem_we, 0);
    chk("rr_words2", words, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Inverse of the `signext` immediate path: accepts symbolic LDUR/STUR/CBZ requests, range-checks the 64-bit immediate, and packs each request into a 32-bit LEGv8 instruction word. It then writes the word into instruction memory at an auto-incrementing address. It sits beside `imem` as the program loader for benches and boot, and flags any immediate that `signext` could not reproduce.

## Interface
- `ADDR_W`, default 6, imem word-address width; capacity is 2^ADDR_W words.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse; clears the address/counters and enters RUN.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  encoder can accept a request.
- `in_fmt`  in  2  00 LDUR, 01 STUR, 10 CBZ, 11 reserved.
- `in_rt`, `in_rn`  in  5 each  register fields; `in_rn` is ignored for CBZ.
- `in_imm`  in  64  signed immediate; byte offset for CBZ.
- `in_last`  in  1  marks the final request of the program.
- `imem_we`  out  1  write strobe.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  encoded instruction.
- `err`  out  1  one-cycle pulse on a rejected request.
- `err_code`  out  2  01 range, 10 misaligned, 11 bad fmt; holds the last value.
- `err_count`  out  8  rejected requests, saturating at 255.
- `words`  out  ADDR_W+1  instructions written since `start`.
- `done`  out  1  level signal, high in DONE.
- `full`  out  1  level signal, high in FULL.

## Operation
- States: IDLE, RUN, DONE, FULL. Reset → IDLE.
- `start` has priority in every state. It clears `imem_addr`, `words`, `err_count` and `err_code`, drops any in-flight beat, and enters RUN.
- A request is accepted when `in_valid && in_ready`. `in_ready` = (state==RUN) && !stall, where stall is high in the cycle after accepting a beat whose write would fill the last address, or a `last` beat.
- Encoding:
  - LDUR: {11'b111_1100_0010, imm9, 2'b00, rn, rt}.
  - STUR: {11'b111_1100_0000, imm9, 2'b00, rn, rt}.
  - CBZ: {8'b1011_0100, imm19, rt}, with imm19 = in_imm[20:2].
- Range checks:
  - D-format requires −256 ≤ imm ≤ 255, i.e. bits 63:8 are all equal.
  - CBZ requires imm[1:0]==0 (otherwise code 10) and −2^20 ≤ imm ≤ 2^20−4 (otherwise code 01).
  - Check priority: fmt > alignment > range.
- On a valid beat, write the word at `imem_addr`, then increment the address and `words`.
- On an invalid beat, do not write and do not change the address. Pulse `err`, load `err_code`, and increment `err_count`.
- Transitions out of RUN:
  - After a `last` beat, whether written or rejected, go to DONE.
  - After writing address 2^ADDR_W−1 without `last`, go to FULL.
  - If `last` coincides with the final address, DONE wins.
- DONE and FULL hold `in_ready`=0 and keep all counters until `start` or `reset`.

## Timing
- Reset values: state IDLE; `in_ready`, `imem_we`, `err`, `done` and `full` all 0; `imem_addr`, `imem_wdata`, `words`, `err_count` and `err_code` all 0.
- Latency: accept on edge N produces `imem_we`/`err` registered and visible during cycle N+1.
- Throughput is one request per cycle in RUN, except the stall cycle after a terminal beat.
- `done`/`full` rise in the same cycle as the terminal write or error pulse.
- `imem_addr` shows the address being written while `imem_we`=1. It updates on the following edge and wraps only via `start`.
- A `reset` or `start` that lands in the same cycle as a write strobe lets that write complete. The in-flight registered beat is then discarded, so no write or error pulse follows.

## Structure
- `legv8_pkg`, shared, holds:
  - the fmt enum;
  - the LDUR/STUR/CBZ opcode constants, already used by `signext` decode;
  - the err_code localparams;
  - the immediate range limits.
- Sub-module `instr_pack`: purely combinational, (fmt, rt, rn, imm) → (word, ok, code). `instr_encoder` holds the request register, FSM and counters.

## Test plan
- LDUR rt=1, rn=2, imm=−256 → one write, addr 0, wdata 32'hF8500041, `words`=1.
- STUR rt=3, rn=4, imm=1, then CBZ rt=5, imm=−1024 with `last` → wdata 32'hF8001083 at addr 0, then 32'hB4FFE005 at addr 1. `done`=1, `in_ready`=0.
- LDUR imm=256, then CBZ imm=6 → no writes; two `err` pulses with codes 01 then 10; `err_count`=2; addr stays 0.
- fmt=11 with `last` → `err` pulse with code 11, then DONE with `words`=0.
- ADDR_W=2, five back-to-back valid requests → four writes to addresses 0–3, `full`=1; the fifth request is never accepted.
- Assert `start` while a beat is in flight, and separately assert `reset` mid-RUN → the dropped beat produces no write; counters and address read 0 afterwards.
